cpu_pipeline_fixed: RTL and testbench

- Five-stage in-order RV32I integer pipeline (IF, ID, EX, MEM, WB) supporting register-register ALU ops, register-immediate ALU ops and LUI.
- Contains its own instruction memory (instance `imem`, array `imem[0:1023]` of 32-bit words) and register file (instance `register_file`, array `registers[0:31]`).
- Benches load programs and inspect state hierarchically through these two instance/array names, so both names are fixed.
- Top-level execution core for bring-up; debug outputs expose PC, fetched word, stage occupancy and x1–x3.

---
 rtl/cpu_pipeline_fixed.sv | 267 ++++++++++++++++++++++++++
 tb/tb_cpu_pipeline_fixed.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_pipeline_fixed.sv
// ------------------------------------------------------------------------
// cpu_pipeline_fixed: 5-stage in-order RV32I ALU/LUI pipeline with internal imem and regfile.
// Optional macro CPU_FWD_EN selects EX forwarding instead of ID stall interlocks.  Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module cpu_imem #(
  parameter int WORDS = 1024,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata
);
  logic [31:0] imem [0:WORDS-1];

  // Load port is held inactive by the core; contents are preloaded externally.
  always @(posedge clk) begin
    if (we) imem[waddr] <= wdata;
  end

  assign rdata = imem[raddr];
endmodule

module cpu_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  output logic [31:0] dbg1,
  output logic [31:0] dbg2,
  output logic [31:0] dbg3
);
  logic [31:0] registers [0:31];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) registers[i] <= '0;
    end else if (we && (waddr != 5'd0)) begin
      registers[waddr] <= wdata;
    end
  end

  // Write-through: a same-cycle WB write is visible to the ID read.
  always_comb begin
    rdata1 = registers[raddr1];
    rdata2 = registers[raddr2];
    if (raddr1 == 5'd0) rdata1 = '0;
    else if (we && (waddr == raddr1)) rdata1 = wdata;
    if (raddr2 == 5'd0) rdata2 = '0;
    else if (we && (waddr == raddr2)) rdata2 = wdata;
  end

  assign dbg1 = registers[1];
  assign dbg2 = registers[2];
  assign dbg3 = registers[3];
endmodule

module cpu_pipeline_fixed #(
  parameter int          IMEM_WORDS = 1024,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] pc_current,
  output logic [31:0] instruction_debug,
  output logic [3:0]  pipeline_state,
  output logic [31:0] debug_reg1,
  output logic [31:0] debug_reg2,
  output logic [31:0] debug_reg3
);
  localparam int IDX_W = $clog2(IMEM_WORDS);

  logic [31:0] pc_q, pc_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        idex_valid_q, idex_valid_d, idex_we_q, idex_we_d, idex_alt_q, idex_alt_d;
  logic [4:0]  idex_rd_q, idex_rd_d;
  logic [2:0]  idex_f3_q, idex_f3_d;
  logic [31:0] idex_a_q, idex_a_d, idex_b_q, idex_b_d;
`ifdef CPU_FWD_EN
  logic [4:0]  idex_rs1_q, idex_rs1_d, idex_rs2_q, idex_rs2_d;
`endif
  logic        exmem_valid_q, exmem_valid_d, exmem_we_q, exmem_we_d;
  logic [4:0]  exmem_rd_q, exmem_rd_d;
  logic [31:0] exmem_res_q, exmem_res_d;
  logic        memwb_valid_q, memwb_valid_d, memwb_we_q, memwb_we_d;
  logic [4:0]  memwb_rd_q, memwb_rd_d;
  logic [31:0] memwb_res_q, memwb_res_d;

  logic [31:0] fetch_word, rs1_val, rs2_val, imm_i, imm_u;
  logic [6:0]  opcode, f7;
  logic [4:0]  rd, src1, src2;
  logic [2:0]  f3;
  logic        is_op, is_opimm, is_lui, writes, stall;
  logic [31:0] op_a, op_b, sra_res, alu_res;

  cpu_imem #(.WORDS(IMEM_WORDS)) imem (
    .clk(clk), .raddr(pc_q[IDX_W+1:2]), .rdata(fetch_word),
    .we(1'b0), .waddr('0), .wdata('0)
  );

  cpu_regfile register_file (
    .clk(clk), .reset(reset), .raddr1(src1), .raddr2(src2),
    .rdata1(rs1_val), .rdata2(rs2_val), .we(memwb_we_q), .waddr(memwb_rd_q),
    .wdata(memwb_res_q), .dbg1(debug_reg1), .dbg2(debug_reg2), .dbg3(debug_reg3)
  );

  always_comb begin
    opcode   = ifid_instr_q[6:0];
    rd       = ifid_instr_q[11:7];
    f3       = ifid_instr_q[14:12];
    f7       = ifid_instr_q[31:25];
    imm_i    = {{20{ifid_instr_q[31]}}, ifid_instr_q[31:20]};
    imm_u    = {ifid_instr_q[31:12], 12'b0};
    is_op    = (opcode == 7'b0110011) && ((f7 == 7'b0000000) ||
               ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))));
    is_opimm = 1'b0;
    if (opcode == 7'b0010011) begin
      case (f3)
        3'b001:  is_opimm = (f7 == 7'b0000000);
        3'b101:  is_opimm = (f7 == 7'b0000000) || (f7 == 7'b0100000);
        default: is_opimm = 1'b1;
      endcase
    end
    is_lui = (opcode == 7'b0110111);
    writes = (is_op || is_opimm || is_lui) && (rd != 5'd0);
    // Unused sources read as x0, which also gives LUI a zero A operand.
    src1   = (is_op || is_opimm) ? ifid_instr_q[19:15] : 5'd0;
    src2   = is_op ? ifid_instr_q[24:20] : 5'd0;
  end

`ifdef CPU_FWD_EN
  assign stall = 1'b0;
`else
  function automatic logic raw_hit(input logic [4:0] src);
    return (src != 5'd0) &&
           ((idex_we_q && (idex_rd_q == src)) ||
            (exmem_we_q && (exmem_rd_q == src)) ||
            (memwb_we_q && (memwb_rd_q == src)));
  endfunction
  assign stall = ifid_valid_q && (raw_hit(src1) || raw_hit(src2));
`endif

  always_comb begin
    op_a = idex_a_q;
    op_b = idex_b_q;
`ifdef CPU_FWD_EN
    if (idex_rs1_q != 5'd0) begin
      if (exmem_we_q && (exmem_rd_q == idex_rs1_q)) op_a = exmem_res_q;
      else if (memwb_we_q && (memwb_rd_q == idex_rs1_q)) op_a = memwb_res_q;
    end
    if (idex_rs2_q != 5'd0) begin
      if (exmem_we_q && (exmem_rd_q == idex_rs2_q)) op_b = exmem_res_q;
      else if (memwb_we_q && (memwb_rd_q == idex_rs2_q)) op_b = memwb_res_q;
    end
`endif
  end

  always_comb begin
    sra_res = $signed(op_a) >>> op_b[4:0];
    case (idex_f3_q)
      3'b000:  alu_res = idex_alt_q ? (op_a - op_b) : (op_a + op_b);
      3'b001:  alu_res = op_a << op_b[4:0];
      3'b010:  alu_res = {31'b0, ($signed(op_a) < $signed(op_b))};
      3'b011:  alu_res = {31'b0, (op_a < op_b)};
      3'b100:  alu_res = op_a ^ op_b;
      3'b101:  alu_res = idex_alt_q ? sra_res : (op_a >> op_b[4:0]);
      3'b110:  alu_res = op_a | op_b;
      default: alu_res = op_a & op_b;
    endcase
  end

  always_comb begin
    pc_d         = pc_q + 32'd4;
    ifid_valid_d = 1'b1;
    ifid_instr_d = fetch_word;
    if (stall) begin
      pc_d         = pc_q;
      ifid_valid_d = ifid_valid_q;
      ifid_instr_d = ifid_instr_q;
    end
    idex_valid_d  = ifid_valid_q && !stall;
    idex_we_d     = idex_valid_d && writes;
    idex_rd_d     = rd;
    idex_f3_d     = is_lui ? 3'b000 : f3;
    idex_alt_d    = f7[5] && (is_op || (f3 == 3'b101)) && !is_lui;
    idex_a_d      = rs1_val;
    idex_b_d      = is_op ? rs2_val : (is_lui ? imm_u : imm_i);
`ifdef CPU_FWD_EN
    idex_rs1_d    = src1;
    idex_rs2_d    = src2;
`endif
    exmem_valid_d = idex_valid_q;
    exmem_we_d    = idex_we_q;
    exmem_rd_d    = idex_rd_q;
    exmem_res_d   = alu_res;
    memwb_valid_d = exmem_valid_q;
    memwb_we_d    = exmem_we_q;
    memwb_rd_d    = exmem_rd_q;
    memwb_res_d   = exmem_res_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      ifid_valid_q  <= 1'b0;
      ifid_instr_q  <= '0;
      idex_valid_q  <= 1'b0;
      idex_we_q     <= 1'b0;
      idex_alt_q    <= 1'b0;
      idex_rd_q     <= '0;
      idex_f3_q     <= '0;
      idex_a_q      <= '0;
      idex_b_q      <= '0;
`ifdef CPU_FWD_EN
      idex_rs1_q    <= '0;
      idex_rs2_q    <= '0;
`endif
      exmem_valid_q <= 1'b0;
      exmem_we_q    <= 1'b0;
      exmem_rd_q    <= '0;
      exmem_res_q   <= '0;
      memwb_valid_q <= 1'b0;
      memwb_we_q    <= 1'b0;
      memwb_rd_q    <= '0;
      memwb_res_q   <= '0;
    end else begin
      pc_q          <= pc_d;
      ifid_valid_q  <= ifid_valid_d;
      ifid_instr_q  <= ifid_instr_d;
      idex_valid_q  <= idex_valid_d;
      idex_we_q     <= idex_we_d;
      idex_alt_q    <= idex_alt_d;
      idex_rd_q     <= idex_rd_d;
      idex_f3_q     <= idex_f3_d;
      idex_a_q      <= idex_a_d;
      idex_b_q      <= idex_b_d;
`ifdef CPU_FWD_EN
      idex_rs1_q    <= idex_rs1_d;
      idex_rs2_q    <= idex_rs2_d;
`endif
      exmem_valid_q <= exmem_valid_d;
      exmem_we_q    <= exmem_we_d;
      exmem_rd_q    <= exmem_rd_d;
      exmem_res_q   <= exmem_res_d;
      memwb_valid_q <= memwb_valid_d;
      memwb_we_q    <= memwb_we_d;
      memwb_rd_q    <= memwb_rd_d;
      memwb_res_q   <= memwb_res_d;
    end
  end

  assign pc_current        = pc_q;
  assign instruction_debug = fetch_word;
  assign pipeline_state    = {memwb_valid_q, exmem_valid_q, idex_valid_q, ifid_valid_q};
endmodule

`default_nettype wire

// File: tb/tb_cpu_pipeline_fixed.sv
// ------------------------------------------------------------------------
// tb_cpu_pipeline_fixed: self-checking bench for cpu_pipeline_fixed (ISA-level reference model).
// Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module tb_cpu_pipeline_fixed;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_current, instruction_debug, debug_reg1, debug_reg2, debug_reg3;
  logic [3:0]  pipeline_state;

  cpu_pipeline_fixed dut (
    .clk(clk), .reset(reset), .pc_current(pc_current),
    .instruction_debug(instruction_debug), .pipeline_state(pipeline_state),
    .debug_reg1(debug_reg1), .debug_reg2(debug_reg2), .debug_reg3(debug_reg3)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] NOP = 32'h0000_0013;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model_regs [32];

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd);
    return {imm, rd, 7'b0110111};
  endfunction

  // Architectural (one instruction at a time) interpretation of the supported subset.
  function automatic void model_exec(input logic [31:0] ins);
    logic [31:0] a, b, res;
    logic        ok;
    a   = model_regs[ins[19:15]];
    res = '0;
    ok  = 1'b1;
    case (ins[6:0])
      7'b0110011: begin
        b = model_regs[ins[24:20]];
        if (ins[31:25] == 7'h00) begin
          case (ins[14:12])
            3'd0: res = a + b;
            3'd1: res = a << b[4:0];
            3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: res = (a < b) ? 32'd1 : 32'd0;
            3'd4: res = a ^ b;
            3'd5: res = a >> b[4:0];
            3'd6: res = a | b;
            default: res = a & b;
          endcase
        end else if (ins[31:25] == 7'h20 && ins[14:12] == 3'd0) res = a - b;
        else if (ins[31:25] == 7'h20 && ins[14:12] == 3'd5) res = $unsigned($signed(a) >>> b[4:0]);
        else ok = 1'b0;
      end
      7'b0010011: begin
        b = {{20{ins[31]}}, ins[31:20]};
        case (ins[14:12])
          3'd0: res = a + b;
          3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          3'd3: res = (a < b) ? 32'd1 : 32'd0;
          3'd4: res = a ^ b;
          3'd6: res = a | b;
          3'd7: res = a & b;
          3'd1: if (ins[31:25] == 7'h00) res = a << ins[24:20]; else ok = 1'b0;
          default: begin
            if (ins[31:25] == 7'h00) res = a >> ins[24:20];
            else if (ins[31:25] == 7'h20) res = $unsigned($signed(a) >>> ins[24:20]);
            else ok = 1'b0;
          end
        endcase
      end
      7'b0110111: res = {ins[31:12], 12'b0};
      default: ok = 1'b0;
    endcase
    if (ok && ins[11:7] != 5'd0) model_regs[ins[11:7]] = res;
  endfunction

  function automatic void model_run(input logic [31:0] prog[$]);
    for (int k = 0; k < 32; k++) model_regs[k] = '0;
    foreach (prog[k]) model_exec(prog[k]);
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] r;
    int          kind;
    kind = $urandom_range(0, 9);
    rd   = 5'($urandom_range(0, 7));
    rs1  = 5'($urandom_range(0, 7));
    rs2  = 5'($urandom_range(0, 7));
    f3   = 3'($urandom_range(0, 7));
    r    = $urandom;
    case (kind)
      0, 1, 2: return enc_r(((f3 == 3'd0 || f3 == 3'd5) && r[0]) ? 7'h20 : 7'h00, rs2, rs1, f3, rd);
      3, 4: begin
        if (f3 == 3'd1 || f3 == 3'd5) f3 = 3'd0;
        return enc_i(r[31:20], rs1, f3, rd);
      end
      5: return enc_i({(r[0] && r[1]) ? 7'h20 : 7'h00, r[24:20]}, rs1, r[0] ? 3'd5 : 3'd1, rd);
      6: return enc_u(r[31:12], rd);
      7: return enc_r(7'h01, rs2, rs1, f3, rd);
      8: return {r[31:7], 7'b0100011};
      default: return enc_i({7'h20, r[24:20]}, rs1, 3'd1, rd);
    endcase
  endfunction

  task automatic load_program(input logic [31:0] prog[$]);
    for (int i = 0; i < 1024; i++) dut.imem.imem[i] = NOP;
    foreach (prog[i]) dut.imem.imem[i] = prog[i];
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", {28'b0, pipeline_state}, 32'h0);
    check("reset_pc", pc_current, 32'h0);
    reset = 1'b0;
  endtask

  task automatic check_model(input string tag);
    for (int k = 0; k < 32; k++)
      check($sformatf("%s_x%0d", tag, k), dut.register_file.registers[k], model_regs[k]);
  endtask

  logic [31:0] prog [$];
  int          bubbles;
  logic        seen;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{"addi_x0",   enc_i(12'd7, 5'd0, 3'd0, 5'd0),           5'd0,  32'h0000_0000};
    vecs[1]  = '{"add_x5",    enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd5),     5'd5,  32'h0000_0000};
    vecs[2]  = '{"lui_x6",    enc_u(20'h80000, 5'd6),                   5'd6,  32'h8000_0000};
    vecs[3]  = '{"srai_x7",   enc_i({7'h20, 5'd4}, 5'd6, 3'd5, 5'd7),   5'd7,  32'hf800_0000};
    vecs[4]  = '{"srli_x8",   enc_i(12'd4, 5'd6, 3'd5, 5'd8),           5'd8,  32'h0800_0000};
    vecs[5]  = '{"sltu_x9",   enc_r(7'h00, 5'd6, 5'd0, 3'd3, 5'd9),     5'd9,  32'h0000_0001};
    vecs[6]  = '{"slt_x10",   enc_r(7'h00, 5'd0, 5'd6, 3'd2, 5'd10),    5'd10, 32'h0000_0001};
    vecs[7]  = '{"sub_x11",   enc_r(7'h20, 5'd9, 5'd0, 3'd0, 5'd11),    5'd11, 32'hffff_ffff};
    vecs[8]  = '{"mul_nop",   enc_r(7'h01, 5'd11, 5'd11, 3'd0, 5'd11),  5'd11, 32'hffff_ffff};
    vecs[9]  = '{"xori_x12",  enc_i(12'h0f0, 5'd11, 3'd4, 5'd12),       5'd12, 32'hffff_ff0f};
    vecs[10] = '{"andi_x13",  enc_i(12'hff8, 5'd11, 3'd7, 5'd13),       5'd13, 32'hffff_fff8};
    vecs[11] = '{"sll_x14",   enc_r(7'h00, 5'd9, 5'd9, 3'd1, 5'd14),    5'd14, 32'h0000_0002};
    vecs[12] = '{"or_x15",    enc_r(7'h00, 5'd9, 5'd14, 3'd6, 5'd15),   5'd15, 32'h0000_0003};
    vecs[13] = '{"slti_x16",  enc_i(12'hfff, 5'd6, 3'd2, 5'd16),        5'd16, 32'h0000_0001};
    vecs[14] = '{"sltiu_x17", enc_i(12'hfff, 5'd9, 3'd3, 5'd17),        5'd17, 32'h0000_0001};
    vecs[15] = '{"srl_x18",   enc_r(7'h00, 5'd9, 5'd11, 3'd5, 5'd18),   5'd18, 32'h7fff_ffff};
    vecs[16] = '{"sra_x19",   enc_r(7'h20, 5'd9, 5'd11, 3'd5, 5'd19),   5'd19, 32'hffff_ffff};

    // Idle on NOP-filled memory: fill pattern, PC stepping, zero registers.
    prog = {};
    load_program(prog);
    do_reset();
    check("idle_fetch_word", instruction_debug, NOP);
    for (int e = 1; e <= 6; e++) begin
      step(1);
      check($sformatf("idle_state_e%0d", e), {28'b0, pipeline_state},
            (e >= 4) ? 32'hf : 32'((1 << e) - 1));
      check($sformatf("idle_pc_e%0d", e), pc_current, 32'(4 * e));
    end
    step(10);
    model_run(prog);
    check_model("idle");

    // Dependent sequence at distance 1 and 2.
    prog = {32'h00a00093, 32'h00500113, 32'h002081b3};
    load_program(prog);
    do_reset();
    bubbles = 0;
    seen    = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      step(1);
`ifdef CPU_FWD_EN
      if (c == 7) check("fwd_x3_by_edge7", dut.register_file.registers[3], 32'h0000_000f);
`endif
      if (pipeline_state[1]) seen = 1'b1;
      else if (seen) bubbles++;
    end
`ifdef CPU_FWD_EN
    check("fwd_bubble_count", 32'(bubbles), 32'd0);
`else
    check("stall_bubble_seen", {31'b0, (bubbles > 0)}, 32'd1);
`endif
    step(8);
    check("dep_x1", debug_reg1, 32'h0000_000a);
    check("dep_x2", debug_reg2, 32'h0000_0005);
    check("dep_x3", debug_reg3, 32'h0000_000f);
    for (int k = 4; k < 32; k++)
      check($sformatf("dep_x%0d_zero", k), dut.register_file.registers[k], 32'h0);

    // Reset asserted with the program in flight, then a full re-execution.
    load_program(prog);
    do_reset();
    step(6);
    reset = 1'b1;
    step(1);
    check("midrst_pc", pc_current, 32'h0);
    check("midrst_state", {28'b0, pipeline_state}, 32'h0);
    for (int k = 0; k < 32; k++)
      check($sformatf("midrst_x%0d", k), dut.register_file.registers[k], 32'h0);
    reset = 1'b0;
    step(20);
    check("rerun_x1", debug_reg1, 32'h0000_000a);
    check("rerun_x2", debug_reg2, 32'h0000_0005);
    check("rerun_x3", debug_reg3, 32'h0000_000f);

    // Table-driven ALU coverage, run back to back as one program.
    prog = {};
    foreach (vecs[i]) prog.push_back(vecs[i].instr);
    load_program(prog);
    do_reset();
    step(90);
    for (int i = 0; i < 17; i++)
      check(vecs[i].name, dut.register_file.registers[vecs[i].rd], vecs[i].exp);

    // Random programs over x0..x7 against the sequential reference model.
    for (int p = 0; p < 5; p++) begin
      prog = {};
      for (int i = 0; i < 24; i++) prog.push_back(rand_instr());
      load_program(prog);
      do_reset();
      step(24 * 4 + 12);
      model_run(prog);
      check_model($sformatf("rand%0d", p));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
